pipe_ctrl: RTL and testbench

//   Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB) built around the ID-stage decoder.

---
 rtl/core_pkg.sv | 21 ++
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl_hazard_detect.sv | 34 +++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core pipeline controller:
// RV32 major-opcode constants and the sequencer state encoding.
package core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
// master: datapath side (drives decoded/EX status, receives controls).
// slave:  the sequencer itself.
interface pipe_ctrl_if;

    logic [6:0] opcode_id;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       core_end;
    logic [4:0] rd_ex;
    logic       mem_read_ex;
    logic       branch_taken_ex;
    logic       imem_valid;

    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       halted;
    logic [1:0] state_o;

    modport master (
        output opcode_id, rs1_id, rs2_id, core_end, rd_ex,
               mem_read_ex, branch_taken_ex, imem_valid,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, halted, state_o
    );

    modport slave (
        input  opcode_id, rs1_id, rs2_id, core_end, rd_ex,
               mem_read_ex, branch_taken_ex, imem_valid,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, halted, state_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads a
// register that the load currently in EX has not yet produced.
module hazard_detect
    import core_pkg::*;
(
    input  logic [6:0] opcode_id,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_ex,
    input  logic       mem_read_ex,
    output logic       load_use
);

    logic uses_rs1;
    logic uses_rs2;

    // Decode which source operands the ID instruction really reads, then match against EX rd.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode_id)
            OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
            default:                  uses_rs1 = 1'b1;
        endcase
        case (opcode_id)
            OP_OP, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default:                    uses_rs2 = 1'b0;
        endcase
        load_use = mem_read_ex && (rd_ex != 5'd0) &&
                   ((uses_rs1 && (rs1_id == rd_ex)) ||
                    (uses_rs2 && (rs2_id == rd_ex)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/MEM/WB core: PC/IF-ID/ID-EX
// control, load-use stalls, branch flushes and the end-of-program
// drain-then-halt sequence.
// Optional feature macro: PIPE_PERF_CNT_EN adds stall/flush counters.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    pipe_ctrl_if.slave       bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          load_use;

    hazard_detect u_hazard_detect (
        .opcode_id   (bus.opcode_id),
        .rs1_id      (bus.rs1_id),
        .rs2_id      (bus.rs2_id),
        .rd_ex       (bus.rd_ex),
        .mem_read_ex (bus.mem_read_ex),
        .load_use    (load_use)
    );

    // Sequencer state and drain countdown.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.core_end) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= HALT;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    // Pipeline controls decoded from current state and hazards; forced quiet during reset.
    // A core_end seen in RUN already applies drain controls in that same cycle.
    always_comb begin
        bus.pc_we        = 1'b0;
        bus.if_id_we     = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        bus.halted       = 1'b0;
        bus.state_o      = rstn ? state : RUN;
        if (rstn) begin
            case (state)
                RUN: begin
                    if (bus.core_end) begin
                        bus.if_id_flush  = 1'b1;
                        bus.id_ex_bubble = 1'b1;
                    end else if (bus.branch_taken_ex) begin
                        bus.pc_we        = 1'b1;
                        bus.if_id_flush  = 1'b1;
                        bus.id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        bus.id_ex_bubble = 1'b1;
                    end else if (!bus.imem_valid) begin
                        bus.if_id_flush  = 1'b1;
                    end else begin
                        bus.pc_we        = 1'b1;
                        bus.if_id_we     = 1'b1;
                    end
                end
                DRAIN: begin
                    bus.if_id_flush  = 1'b1;
                    bus.id_ex_bubble = 1'b1;
                end
                HALT:    bus.halted = 1'b1;
                default: bus.halted = 1'b0;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating stall/flush event counters, live only while running.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN) begin
            if (load_use && !bus.branch_taken_ex && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bus.branch_taken_ex && !bus.core_end && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver issues per-cycle stimulus and
// queues the expected controls from a cycle-count reference model; a
// monitor pops and compares on the falling edge. Honours PIPE_PERF_CNT_EN.
module tb_pipe_ctrl;

    localparam int DRAIN = 3;

    typedef struct {
        logic        pc_we;
        logic        if_id_we;
        bit          we_chk;
        logic        flush;
        logic        bubble;
        logic        halted;
        logic [1:0]  st;
        longint      stall;
        longint      flushc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    pipe_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (.clk(clk), .rstn(rstn), .bus(bus));
`endif

    always #5 clk = ~clk;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    // Reference model: cycles elapsed since core_end was accepted (-1 = still running).
    int     since_end = -1;
    longint m_stall = 0;
    longint m_flush = 0;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, c, act, req);
        end
    endtask

    function automatic bit ref_load_use(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                        input logic [4:0] rd, input logic mr);
        bit reads1, reads2;
        reads1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        reads2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return mr && rd != 0 && ((reads1 && r1 == rd) || (reads2 && r2 == rd));
    endfunction

    // Apply one cycle of stimulus, queue its expected response, advance the model past the next edge.
    task automatic step(input logic rn, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic ce, input logic [4:0] rd, input logic mr, input logic br, input logic iv);
        exp_t e;
        bit lu;
        @(posedge clk);
        #1;
        cyc++;
        rstn = rn;
        bus.opcode_id = op; bus.rs1_id = r1; bus.rs2_id = r2; bus.core_end = ce;
        bus.rd_ex = rd; bus.mem_read_ex = mr; bus.branch_taken_ex = br; bus.imem_valid = iv;
        lu = ref_load_use(op, r1, r2, rd, mr);
        e = '{pc_we:0, if_id_we:0, we_chk:1, flush:0, bubble:0, halted:0, st:2'd0,
              stall:m_stall, flushc:m_flush, cyc:cyc};
        if (rn) begin
            if (since_end < 0) begin
                if (ce) begin
                    e.flush = 1; e.bubble = 1; e.we_chk = 0;
                end else if (br) begin
                    e.pc_we = 1; e.flush = 1; e.bubble = 1; e.we_chk = 0;
                end else if (lu) begin
                    e.bubble = 1;
                end else if (!iv) begin
                    e.flush = 1; e.we_chk = 0;
                end else begin
                    e.pc_we = 1; e.if_id_we = 1;
                end
            end else if (since_end < DRAIN) begin
                e.flush = 1; e.bubble = 1; e.we_chk = 0; e.st = 2'd1;
            end else begin
                e.halted = 1; e.st = 2'd2;
            end
        end
        q.push_back(e);
        if (!rn) begin
            since_end = -1; m_stall = 0; m_flush = 0;
        end else if (since_end < 0) begin
            if (lu && !br && m_stall < SAT) m_stall++;
            if (br && !ce && m_flush < SAT) m_flush++;
            if (ce) since_end = 0;
        end else if (since_end <= DRAIN) begin
            since_end++;
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_we", e.cyc, 64'(bus.pc_we), 64'(e.pc_we));
                if (e.we_chk) chk("if_id_we", e.cyc, 64'(bus.if_id_we), 64'(e.if_id_we));
                chk("if_id_flush", e.cyc, 64'(bus.if_id_flush), 64'(e.flush));
                chk("id_ex_bubble", e.cyc, 64'(bus.id_ex_bubble), 64'(e.bubble));
                chk("halted", e.cyc, 64'(bus.halted), 64'(e.halted));
                chk("state_o", e.cyc, 64'(bus.state_o), 64'(e.st));
`ifdef PIPE_PERF_CNT_EN
                chk("stall_cnt", e.cyc, 64'(stall_cnt), 64'(e.stall));
                chk("flush_cnt", e.cyc, 64'(flush_cnt), 64'(e.flushc));
`endif
            end
        end
    end

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    initial begin
        logic [6:0] ops [10];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};
        bus.opcode_id = '0; bus.rs1_id = '0; bus.rs2_id = '0; bus.core_end = 0;
        bus.rd_ex = '0; bus.mem_read_ex = 0; bus.branch_taken_ex = 0; bus.imem_valid = 0;

        // Reset, then plain flow.
        repeat (2) step(0, OPC_OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1);
        repeat (5) step(1, OPC_OP, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1);
        // Load-use on rs2 only, then the non-stalling variants.
        step(1, OPC_OP,  5'd7, 5'd5, 0, 5'd5, 1, 0, 1);
        step(1, OPC_OP,  5'd7, 5'd5, 0, 5'd9, 0, 0, 1);
        step(1, OPC_IMM, 5'd7, 5'd5, 0, 5'd5, 1, 0, 1);
        step(1, OPC_OP,  5'd0, 5'd0, 0, 5'd0, 1, 0, 1);
        // Branch together with load-use: branch wins.
        step(1, OPC_OP,  5'd5, 5'd5, 0, 5'd5, 1, 1, 1);
        // Two fetch bubbles, then resume.
        repeat (2) step(1, OPC_OP, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0);
        repeat (2) step(1, OPC_OP, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1);
        // Randomized traffic with occasional end/reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 89) != 0),
                 ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 59) == 0), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0));
        end
        // Clean end-of-program: drain then halt while branch toggles.
        step(0, OPC_OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1);
        step(1, OPC_OP, 5'd1, 5'd2, 1, 5'd0, 0, 0, 1);
        repeat (DRAIN) step(1, OPC_OP, 5'd5, 5'd5, 0, 5'd5, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, OPC_OP, 5'd1, 5'd2, 1'(i), 5'd0, 0, 1'(i), 1);
        // Reset in the middle of a drain.
        step(1, OPC_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
        step(0, OPC_OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1);
        step(1, OPC_OP, 5'd5, 5'd5, 0, 5'd5, 1, 0, 1);
        step(1, OPC_OP, 5'd1, 5'd2, 1, 5'd0, 0, 0, 1);
        step(1, OPC_OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1);
        step(0, OPC_OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1);
        repeat (3) step(1, OPC_OP, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
